// File: rtl/cat_io_pkg.sv
// Shared types and sizing helpers for the AD9361 CMOS IO mode sequencer.
package cat_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUTE,
    ST_RESET,
    ST_SETTLE,
    ST_LOCKCHK,
    ST_FAIL
  } cat_io_state_e;

  // Bits needed to hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cat_io_hb_detect.sv
// Brings the radio_clk heartbeat toggle into the control clock domain and
// emits a single-cycle pulse for every toggle seen.
module cat_io_hb_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic hb_toggle_i,
  output logic hb_pulse_o
);

  logic sync1_q, sync2_q, last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      sync1_q <= hb_toggle_i;
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
    end
  end

  assign hb_pulse_o = sync2_q ^ last_q;

endmodule

// File: rtl/cat_io_mode_seq.sv
// SISO/MIMO switch and boot sequencer for the AD9361 CMOS IO block; runs on
// the always-on control clock and drives areset/mimo/mute around the switch.
module cat_io_mode_seq
  import cat_io_pkg::*;
#(
  parameter int MUTE_CYCLES    = 8,
  parameter int RST_CYCLES     = 16,
  parameter int SETTLE_CYCLES  = 256,
  parameter int LOCK_EDGES     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRIES    = 2,
  localparam int RW = cnt_width(MAX_RETRIES + 1)
) (
  input  logic          clk,
  input  logic          areset_n,
  input  logic          req_valid,
  input  logic          req_mimo,
  output logic          req_ready,
  output logic          io_areset,
  output logic          io_mimo,
  output logic          tx_mute,
  input  logic          rx_hb_toggle,
  output logic          locked,
  output logic          busy,
  output logic          err,
  output logic [RW-1:0] retry_cnt,
  output cat_io_state_e dbg_state
);

  localparam int MAX_A   = (MUTE_CYCLES > RST_CYCLES) ? MUTE_CYCLES : RST_CYCLES;
  localparam int MAX_B   = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = cnt_width(CNT_MAX);
  localparam int EW      = cnt_width(LOCK_EDGES);

  cat_io_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] edge_q, edge_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          target_q, target_d;
  logic          err_q, err_d;
  logic          io_areset_q, io_areset_d;
  logic          io_mimo_q;
  logic          tx_mute_q, tx_mute_d;
  logic          locked_q, locked_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic          hb_pulse;
  logic          accept;

  cat_io_hb_detect u_hb (
    .clk_i      (clk),
    .rst_ni     (areset_n),
    .hb_toggle_i(rx_hb_toggle),
    .hb_pulse_o (hb_pulse)
  );

  assign accept = req_valid && ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    retry_d  = retry_q;
    target_d = target_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE, ST_FAIL: begin
        if (accept) begin
          target_d = req_mimo;
          err_d    = 1'b0;
          retry_d  = '0;
          state_d  = ST_MUTE;
          cnt_d    = CW'(MUTE_CYCLES - 1);
        end
      end
      ST_MUTE: begin
        if (cnt_q == '0) begin
          state_d = ST_RESET;
          cnt_d   = CW'(RST_CYCLES - 1);
        end else cnt_d = cnt_q - CW'(1);
      end
      ST_RESET: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
        end else cnt_d = cnt_q - CW'(1);
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_LOCKCHK;
          cnt_d   = CW'(TIMEOUT_CYCLES - 1);
          edge_d  = '0;
        end else cnt_d = cnt_q - CW'(1);
      end
      ST_LOCKCHK: begin
        // Lock is tested before the timeout so a last edge on the final cycle still counts.
        if (hb_pulse && (edge_q == EW'(LOCK_EDGES - 1))) begin
          state_d = ST_IDLE;
        end else begin
          if (hb_pulse) edge_d = edge_q + EW'(1);
          if (cnt_q == '0) begin
            if (retry_q < RW'(MAX_RETRIES)) begin
              retry_d = retry_q + RW'(1);
              state_d = ST_RESET;
              cnt_d   = CW'(RST_CYCLES - 1);
            end else begin
              state_d = ST_FAIL;
              err_d   = 1'b1;
            end
          end else cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = CW'(RST_CYCLES - 1);
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the entry edge.
  always_comb begin
    io_areset_d = 1'b0;
    tx_mute_d   = 1'b1;
    locked_d    = 1'b0;
    busy_d      = 1'b1;
    ready_d     = 1'b0;
    case (state_d)
      ST_IDLE: begin
        tx_mute_d = 1'b0;
        locked_d  = 1'b1;
        busy_d    = 1'b0;
        ready_d   = 1'b1;
      end
      ST_MUTE:  io_areset_d = io_areset_q;
      ST_RESET: io_areset_d = 1'b1;
      ST_FAIL: begin
        io_areset_d = 1'b1;
        busy_d      = 1'b0;
        ready_d     = 1'b1;
      end
      default: io_areset_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= CW'(RST_CYCLES - 1);
      edge_q      <= '0;
      retry_q     <= '0;
      target_q    <= 1'b0;
      err_q       <= 1'b0;
      io_areset_q <= 1'b1;
      io_mimo_q   <= 1'b0;
      tx_mute_q   <= 1'b1;
      locked_q    <= 1'b0;
      busy_q      <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edge_q      <= edge_d;
      retry_q     <= retry_d;
      target_q    <= target_d;
      err_q       <= err_d;
      io_areset_q <= io_areset_d;
      tx_mute_q   <= tx_mute_d;
      locked_q    <= locked_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      // mimo moves one cycle into RESET, strictly inside the io_areset window.
      if (state_q == ST_RESET && cnt_q == CW'(RST_CYCLES - 1)) io_mimo_q <= target_q;
    end
  end

  assign req_ready = ready_q;
  assign io_areset = io_areset_q;
  assign io_mimo   = io_mimo_q;
  assign tx_mute   = tx_mute_q;
  assign locked    = locked_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign retry_cnt = retry_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cat_io_mode_seq.sv
// Scenario bench for cat_io_mode_seq: boot, mode switch, timeout/FAIL,
// ignored busy requests, lock/timeout race and mid-sequence reset.
module tb_cat_io_mode_seq;
  import cat_io_pkg::*;

  logic          clk;
  logic          areset_n;
  logic          req_valid;
  logic          req_mimo;
  logic          req_ready;
  logic          io_areset;
  logic          io_mimo;
  logic          tx_mute;
  logic          rx_hb_toggle;
  logic          locked;
  logic          busy;
  logic          err;
  logic [1:0]    retry_cnt;
  cat_io_state_e dbg_state;

  logic hb_en, hb_auto, hb_man;
  int   hb_div;
  int   n_vec, n_err;
  int   mimo_viol, mute_viol;
  logic prev_mimo;

  // {io_mimo, locked, err, tx_mute, retry_cnt} at the end of each sequence
  logic [5:0] exp_q[$];

  // Measurements filled in by sb_wait_pop
  int         busy_cycles, mute_len;
  logic [2:0] retry_seen;

  cat_io_mode_seq dut (
    .clk         (clk),
    .areset_n    (areset_n),
    .req_valid   (req_valid),
    .req_mimo    (req_mimo),
    .req_ready   (req_ready),
    .io_areset   (io_areset),
    .io_mimo     (io_mimo),
    .tx_mute     (tx_mute),
    .rx_hb_toggle(rx_hb_toggle),
    .locked      (locked),
    .busy        (busy),
    .err         (err),
    .retry_cnt   (retry_cnt),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // heartbeat: free-running every 40 clk when enabled, plus manual toggles
  assign rx_hb_toggle = hb_auto ^ hb_man;
  initial begin
    hb_auto = 1'b0;
    hb_div  = 0;
  end
  always @(negedge clk) begin
    if (hb_en) begin
      if (hb_div == 39) begin
        hb_auto = ~hb_auto;
        hb_div  = 0;
      end else hb_div = hb_div + 1;
    end
  end

  // invariant monitor
  initial begin
    mimo_viol = 0;
    mute_viol = 0;
    prev_mimo = 1'b0;
  end
  always @(negedge clk) begin
    if (areset_n) begin
      if (io_mimo !== prev_mimo && io_areset !== 1'b1) mimo_viol = mimo_viol + 1;
      if (locked === 1'b0 && tx_mute !== 1'b1) mute_viol = mute_viol + 1;
    end
    prev_mimo = io_mimo;
  end

  // driver: one-cycle request, leaves caller on the negedge after the accept edge
  task automatic send_req(input logic mimo);
    @(negedge clk);
    req_valid = 1'b1;
    req_mimo  = mimo;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // scoreboard: wait for the sequence to finish, then pop its expectation
  task automatic sb_wait_pop(output logic [5:0] obs, output logic [5:0] exp, output bit ok);
    int  cyc;
    bit  seen_rst;
    cyc = 0;
    seen_rst = 0;
    busy_cycles = 0;
    mute_len = 0;
    retry_seen = 3'b000;
    ok = 1;
    while (busy === 1'b1 && cyc < 20000) begin
      busy_cycles = busy_cycles + 1;
      if (io_areset === 1'b1) seen_rst = 1;
      if (!seen_rst && tx_mute === 1'b1) mute_len = mute_len + 1;
      if (retry_cnt < 3) retry_seen[retry_cnt] = 1'b1;
      @(negedge clk);
      cyc = cyc + 1;
    end
    if (busy !== 1'b0) begin
      n_vec = n_vec + 1;
      n_err = n_err + 1;
      $display("FAIL seq_timeout: busy=%b after %0d cycles, required 0", busy, cyc);
      ok = 0;
    end
    obs = {io_mimo, locked, err, tx_mute, retry_cnt};
    if (exp_q.size() == 0) begin
      n_vec = n_vec + 1;
      n_err = n_err + 1;
      $display("FAIL sb_empty: sequence ended with no expectation queued");
      exp = ~obs;
      ok = 0;
    end else exp = exp_q.pop_front();
  endtask

  task automatic test_reset();
    areset_n  = 1'b0;
    req_valid = 1'b0;
    req_mimo  = 1'b0;
    hb_en     = 1'b0;
    hb_man    = 1'b0;
    repeat (3) @(negedge clk);
    n_vec = n_vec + 1;
    if (io_areset !== 1'b1) begin n_err = n_err + 1; $display("FAIL rst_io_areset: got %b want 1", io_areset); end
    n_vec = n_vec + 1;
    if (io_mimo !== 1'b0) begin n_err = n_err + 1; $display("FAIL rst_io_mimo: got %b want 0", io_mimo); end
    n_vec = n_vec + 1;
    if (tx_mute !== 1'b1) begin n_err = n_err + 1; $display("FAIL rst_tx_mute: got %b want 1", tx_mute); end
    n_vec = n_vec + 1;
    if (locked !== 1'b0) begin n_err = n_err + 1; $display("FAIL rst_locked: got %b want 0", locked); end
    n_vec = n_vec + 1;
    if (busy !== 1'b1) begin n_err = n_err + 1; $display("FAIL rst_busy: got %b want 1", busy); end
    n_vec = n_vec + 1;
    if (err !== 1'b0) begin n_err = n_err + 1; $display("FAIL rst_err: got %b want 0", err); end
    n_vec = n_vec + 1;
    if (req_ready !== 1'b0) begin n_err = n_err + 1; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    n_vec = n_vec + 1;
    if (retry_cnt !== 2'd0) begin n_err = n_err + 1; $display("FAIL rst_retry_cnt: got %0d want 0", retry_cnt); end
  endtask

  task automatic test_boot();
    logic [5:0] obs, exp;
    bit ok;
    hb_en = 1'b1;
    areset_n = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    repeat (15) @(negedge clk);
    n_vec = n_vec + 1;
    if (io_areset !== 1'b1) begin n_err = n_err + 1; $display("FAIL boot_rst_hold: got %b want 1 after 15 clk", io_areset); end
    @(negedge clk);
    n_vec = n_vec + 1;
    if (io_areset !== 1'b0) begin n_err = n_err + 1; $display("FAIL boot_rst_release: got %b want 0 after 16 clk", io_areset); end
    sb_wait_pop(obs, exp, ok);
    n_vec = n_vec + 1;
    if (obs !== exp) begin n_err = n_err + 1; $display("FAIL boot_final: got %b want %b", obs, exp); end
  endtask

  task automatic test_siso_mimo();
    logic [5:0] obs, exp;
    bit ok;
    send_req(1'b1);
    exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
    sb_wait_pop(obs, exp, ok);
    n_vec = n_vec + 1;
    if (mute_len !== 8) begin n_err = n_err + 1; $display("FAIL mimo_mute_lead: got %0d cycles want 8", mute_len); end
    n_vec = n_vec + 1;
    if (obs !== exp) begin n_err = n_err + 1; $display("FAIL mimo_final: got %b want %b", obs, exp); end
  endtask

  task automatic test_no_hb();
    logic [5:0] obs, exp;
    bit ok;
    hb_en = 1'b0;
    send_req(1'b0);
    exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b1, 2'd2});
    sb_wait_pop(obs, exp, ok);
    n_vec = n_vec + 1;
    if (obs !== exp) begin n_err = n_err + 1; $display("FAIL nohb_final: got %b want %b", obs, exp); end
    n_vec = n_vec + 1;
    if (retry_seen !== 3'b111) begin n_err = n_err + 1; $display("FAIL nohb_retries: seen mask %b want 111", retry_seen); end
    n_vec = n_vec + 1;
    if (busy_cycles !== 8 + 3 * (16 + 256 + 4096)) begin
      n_err = n_err + 1;
      $display("FAIL nohb_duration: got %0d busy cycles want %0d", busy_cycles, 8 + 3 * (16 + 256 + 4096));
    end
    n_vec = n_vec + 1;
    if (io_areset !== 1'b1 || req_ready !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL nohb_fail_outputs: io_areset=%b req_ready=%b want 1/1", io_areset, req_ready);
    end
  endtask

  task automatic test_busy_req();
    logic [5:0] obs, exp;
    bit ok;
    int cyc;
    bit ready_seen;
    hb_en = 1'b1;
    send_req(1'b1);
    exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
    n_vec = n_vec + 1;
    if (err !== 1'b0) begin n_err = n_err + 1; $display("FAIL busy_err_clear: got %b want 0", err); end
    cyc = 0;
    while (io_areset !== 1'b0 && cyc < 200) begin
      @(negedge clk);
      cyc = cyc + 1;
    end
    ready_seen = 0;
    req_valid = 1'b1;
    req_mimo  = 1'b0;
    repeat (2) begin
      if (req_ready !== 1'b0) ready_seen = 1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_vec = n_vec + 1;
    if (ready_seen || cyc >= 200) begin
      n_err = n_err + 1;
      $display("FAIL busy_ready: ready_seen=%b settle_wait=%0d want ready 0 in SETTLE", ready_seen, cyc);
    end
    sb_wait_pop(obs, exp, ok);
    n_vec = n_vec + 1;
    if (obs !== exp) begin n_err = n_err + 1; $display("FAIL busy_final: got %b want %b", obs, exp); end
  endtask

  task automatic test_edge_race();
    logic [5:0] obs, exp;
    bit ok;
    int cyc;
    hb_en = 1'b0;
    send_req(1'b1);
    exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
    cyc = 0;
    while (dbg_state !== ST_LOCKCHK && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
    end
    n_vec = n_vec + 1;
    if (cyc >= 1000) begin n_err = n_err + 1; $display("FAIL race_enter: state %0d want LOCKCHK", dbg_state); end
    // toggle k=4093 reaches the FSM exactly on the cycle the window counter hits zero
    for (int k = 1; k <= 4095; k++) begin
      @(posedge clk);
      #1;
      if (k == 100 || k == 200 || k == 300 || k == 4093) hb_man = ~hb_man;
    end
    n_vec = n_vec + 1;
    if (dbg_state !== ST_LOCKCHK || locked !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL race_early: state=%0d locked=%b want LOCKCHK/0 one cycle before expiry", dbg_state, locked);
    end
    @(posedge clk);
    #1;
    n_vec = n_vec + 1;
    if (dbg_state !== ST_IDLE || locked !== 1'b1 || retry_cnt !== 2'd0) begin
      n_err = n_err + 1;
      $display("FAIL race_lock_wins: state=%0d locked=%b retry=%0d want IDLE/1/0", dbg_state, locked, retry_cnt);
    end
    sb_wait_pop(obs, exp, ok);
    n_vec = n_vec + 1;
    if (obs !== exp) begin n_err = n_err + 1; $display("FAIL race_final: got %b want %b", obs, exp); end
  endtask

  task automatic test_mid_reset();
    logic [5:0] obs, exp;
    logic [8:0] rst_vec;
    bit ok;
    int cyc;
    hb_en = 1'b0;
    send_req(1'b1);
    cyc = 0;
    while (dbg_state !== ST_LOCKCHK && cyc < 1000) begin
      @(negedge clk);
      cyc = cyc + 1;
    end
    repeat (10) @(negedge clk);
    areset_n = 1'b0;
    @(posedge clk);
    #1;
    rst_vec = {io_areset, io_mimo, tx_mute, locked, busy, err, req_ready, retry_cnt};
    n_vec = n_vec + 1;
    if (rst_vec !== 9'b1_0_1_0_1_0_0_00 || cyc >= 1000) begin
      n_err = n_err + 1;
      $display("FAIL midrst_values: got %b want 101010000 (lockchk wait %0d)", rst_vec, cyc);
    end
    @(negedge clk);
    areset_n = 1'b1;
    hb_en = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    sb_wait_pop(obs, exp, ok);
    n_vec = n_vec + 1;
    if (obs !== exp) begin n_err = n_err + 1; $display("FAIL midrst_reboot: got %b want %b", obs, exp); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_boot();
    test_siso_mimo();
    test_no_hb();
    test_busy_req();
    test_edge_race();
    test_mid_reset();
    n_vec = n_vec + 1;
    if (mimo_viol !== 0) begin n_err = n_err + 1; $display("FAIL inv_mimo_in_reset: %0d mimo changes with io_areset=0", mimo_viol); end
    n_vec = n_vec + 1;
    if (mute_viol !== 0) begin n_err = n_err + 1; $display("FAIL inv_mute_unlocked: %0d cycles unmuted while unlocked", mute_viol); end
    n_vec = n_vec + 1;
    if (exp_q.size() !== 0) begin n_err = n_err + 1; $display("FAIL sb_leftover: %0d expectations left want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
